// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM states and default byte width.
// Used by uart_tx, baudrate_generator and uart_tx_arbiter.
// Pure declarations; no logic.
package uart_pkg;

  // Default serial byte width shared by the transmitter and its arbiter.
  localparam int DEF_NB_DATA = 8;

  // Transfer sequencing states of the transmit arbiter.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Rotate-and-priority-encode: picks the first requester at or above i_rr_ptr, with wrap.
// Combinational, zero latency.
// No backpressure; o_vld simply reflects whether any request is present.
// With UART_ARB_FIXED_PRIO_EN defined the rotation is forced to 0 (lowest index wins).
module rr_select
  import uart_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int NB_REQ_IDX = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]      i_req,
  input  logic [NB_REQ_IDX-1:0] i_rr_ptr,
  output logic                  o_vld,
  output logic [NB_REQ_IDX-1:0] o_idx
);

  localparam logic [NB_REQ_IDX:0] LP_N = (NB_REQ_IDX+1)'(N_REQ);

  logic [NB_REQ_IDX-1:0] w_rot_amt;
  logic [N_REQ-1:0]      w_rot;
  logic [NB_REQ_IDX:0]   w_ofs;
  logic [NB_REQ_IDX:0]   w_sum;

`ifdef UART_ARB_FIXED_PRIO_EN
  assign w_rot_amt = '0;
`else
  assign w_rot_amt = i_rr_ptr;
`endif

  // Rotate so that bit 0 of w_rot is the requester at the pointer.
  assign w_rot = N_REQ'({i_req, i_req} >> w_rot_amt);
  assign o_vld = |i_req;

  // Offset of the lowest set bit in the rotated vector (scanned downward so lowest wins).
  always_comb begin
    w_ofs = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_ofs = k[NB_REQ_IDX:0];
      end
    end
  end

  // Undo the rotation: pointer plus offset, modulo N_REQ.
  always_comb begin
    w_sum = {1'b0, w_rot_amt} + w_ofs;
    if (w_sum >= LP_N) begin
      w_sum = w_sum - LP_N;
    end
  end

  assign o_idx = w_sum[NB_REQ_IDX-1:0];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte requesters (fixed priority with UART_ARB_FIXED_PRIO_EN).
// Latency: request seen in IDLE at cycle t gives o_tx_start/o_ack at t+1; then waits for the frame to finish.
// Backpressure: no grant while i_tx_available is low; a watchdog aborts if the transmitter never goes busy.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NB_DATA        = DEF_NB_DATA,
  parameter int N_REQ          = 4,
  parameter int NB_REQ_IDX     = $clog2(N_REQ),
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int NB_TIMEOUT     = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*NB_DATA-1:0] i_req_data,
  output logic [N_REQ-1:0]         o_ack,
  output logic                     o_tx_start,
  output logic [NB_DATA-1:0]       o_tx_data,
  input  logic                     i_tx_available,
  output logic                     o_busy,
  output logic [NB_REQ_IDX-1:0]    o_grant_idx,
  output logic                     o_timeout
);

  localparam logic [NB_TIMEOUT-1:0] LP_TIMEOUT  = NB_TIMEOUT'(TIMEOUT_CYCLES);
  localparam logic [NB_REQ_IDX-1:0] LP_LAST_IDX = NB_REQ_IDX'(N_REQ - 1);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [NB_DATA-1:0]    r_tx_data;
  logic [NB_REQ_IDX-1:0] r_grant_idx;
  logic [NB_TIMEOUT-1:0] r_wd;

  logic                  w_sel_vld;
  logic [NB_REQ_IDX-1:0] w_sel_idx;
  logic [NB_REQ_IDX-1:0] w_rr_ptr;
  logic [NB_DATA-1:0]    w_sel_data;
  logic                  w_grant;
  logic                  w_wd_clr;
  logic                  w_wd_inc;

  // ------------------------------------------------------------------
  // Round-robin pointer: only exists when rotation is in use.
  // ------------------------------------------------------------------
`ifdef UART_ARB_FIXED_PRIO_EN
  assign w_rr_ptr = '0;
`else
  logic [NB_REQ_IDX-1:0] r_rr_ptr;

  // Advance the pointer past the winner on every grant; an abort leaves it alone.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= (w_sel_idx == LP_LAST_IDX) ? '0 : w_sel_idx + 1'b1;
    end
  end

  assign w_rr_ptr = r_rr_ptr;
`endif

  rr_select #(
    .N_REQ      (N_REQ),
    .NB_REQ_IDX (NB_REQ_IDX)
  ) u_rr_select (
    .i_req    (i_req),
    .i_rr_ptr (w_rr_ptr),
    .o_vld    (w_sel_vld),
    .o_idx    (w_sel_idx)
  );

  // Mux out the winning requester's byte.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_sel_idx == k[NB_REQ_IDX-1:0]) begin
        w_sel_data = i_req_data[k*NB_DATA +: NB_DATA];
      end
    end
  end

  // ------------------------------------------------------------------
  // Transfer FSM
  // ------------------------------------------------------------------

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and pulse outputs; start/ack/timeout are decoded from the state so
  // a reset removes them in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_wd_clr    = 1'b0;
    w_wd_inc    = 1'b0;
    o_tx_start  = 1'b0;
    o_ack       = '0;
    o_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sel_vld && i_tx_available) begin
          w_grant     = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        o_tx_start         = 1'b1;
        o_ack[r_grant_idx] = 1'b1;
        w_wd_clr           = 1'b1;
        w_state_nxt        = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!i_tx_available) begin
          w_state_nxt = WAIT_DONE;
        end else if (r_wd == LP_TIMEOUT) begin
          o_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_wd_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        // Frame length is bounded by the transmitter itself, so no watchdog here.
        if (i_tx_available) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Latch byte and index at grant; held until the next grant so o_tx_data stays stable.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_tx_data   <= '0;
      r_grant_idx <= '0;
    end else if (w_grant) begin
      r_tx_data   <= w_sel_data;
      r_grant_idx <= w_sel_idx;
    end
  end

  // Watchdog counting cycles spent waiting for the transmitter to go busy.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wd <= '0;
    end else if (w_wd_clr) begin
      r_wd <= '0;
    end else if (w_wd_inc) begin
      r_wd <= r_wd + NB_TIMEOUT'(1);
    end
  end

  assign o_busy      = (r_state != IDLE);
  assign o_tx_data   = r_tx_data;
  assign o_grant_idx = r_grant_idx;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural transmitter stub (short frame).
// Grants are predicted into a scoreboard when requests are driven and compared as starts appear.
// Honours UART_ARB_FIXED_PRIO_EN when predicting winners.
module tb_uart_tx_arbiter;

  localparam int NB_DATA = 8;
  localparam int N_REQ   = 4;
  localparam int TO      = 15;
  localparam int FRAME   = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  o_ack;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        tx_avail;
  logic        o_busy;
  logic [1:0]  o_grant_idx;
  logic        o_timeout;

  logic        stub_avail;
  int          stub_cnt;
  logic        force_busy;
  logic        hold_avail;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = 0;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic [3:0] ack;
    int         cyc;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter #(
    .NB_DATA        (NB_DATA),
    .N_REQ          (N_REQ),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_req          (req),
    .i_req_data     (req_data),
    .o_ack          (o_ack),
    .o_tx_start     (o_tx_start),
    .o_tx_data      (o_tx_data),
    .i_tx_available (tx_avail),
    .o_busy         (o_busy),
    .o_grant_idx    (o_grant_idx),
    .o_timeout      (o_timeout)
  );

  // Transmitter stub: available drops the cycle after a start and stays low FRAME cycles.
  assign tx_avail = force_busy ? 1'b0 : (hold_avail ? 1'b1 : stub_avail);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_avail <= 1'b1;
      stub_cnt   <= 0;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_avail <= 1'b1;
    end else if (o_tx_start && !hold_avail) begin
      stub_avail <= 1'b0;
      stub_cnt   <= FRAME;
    end
  end

  // Monitor: log every start or ack the DUT produces.
  always @(negedge clk) begin
    rec_t r;
    if (!rst && (o_tx_start || o_ack != 4'b0000)) begin
      r.idx  = int'(o_grant_idx);
      r.data = o_tx_data;
      r.ack  = o_ack;
      r.cyc  = cyc;
      obs_q.push_back(r);
    end
  end

  // Expected winner for a request vector given the model pointer.
  function automatic int predict(input logic [3:0] r, input int ptr);
    int start;
    predict = -1;
`ifdef UART_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = ptr;
`endif
    for (int k = 3; k >= 0; k--) begin
      if (r[(start + k) % 4]) predict = (start + k) % 4;
    end
  endfunction

  task automatic push_exp(input int idx);
    rec_t e;
    e.idx  = idx;
    e.data = req_data[idx*8 +: 8];
    e.ack  = 4'b0001 << idx;
    e.cyc  = 0;
    exp_q.push_back(e);
    m_ptr = (idx + 1) % 4;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst        = 1'b1;
    req        = 4'b0000;
    req_data   = 32'h0;
    force_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    m_ptr = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic wait_obs(input int budget);
    while (obs_q.size() < exp_q.size() && budget > 0) begin
      @(posedge clk);
      budget--;
    end
  endtask

  task automatic wait_idle();
    int budget = 200;
    @(negedge clk);
    while (o_busy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_return: o_busy got %b want 0", o_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; req_data = 32'h0; force_busy = 1'b0; hold_avail = 1'b0;
    #1;
    @(negedge clk);
    n_checks++;
    if ({o_busy, o_tx_start, o_timeout, o_ack, o_tx_data, o_grant_idx} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b start=%b to=%b ack=%b data=%h idx=%0d want all 0",
               o_busy, o_tx_start, o_timeout, o_ack, o_tx_data, o_grant_idx);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b starts=%0d want 0/0", o_busy, obs_q.size());
    end
  endtask

  task automatic test_single();
    rec_t e, o;
    logic stable = 1'b1;
    int budget = 200;
    apply_reset();
    req_data[23:16] = 8'hA5;
    req = 4'b0100;
    push_exp(predict(req, m_ptr));
    @(negedge clk);
    n_checks++;
    if (o_ack !== 4'b0100 || o_tx_start !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency: ack=%b start=%b want 0100/1", o_ack, o_tx_start);
    end
    req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (o_tx_start !== 1'b0 || o_ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_pulse: start=%b ack=%b want 0/0000", o_tx_start, o_ack);
    end
    while (o_busy && budget > 0) begin
      if (o_tx_data !== 8'hA5) stable = 1'b0;
      @(negedge clk);
      budget--;
    end
    n_checks++;
    if (!stable || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_hold: data_stable=%b busy=%b want 1/0", stable, o_busy);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL single_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.idx !== e.idx || o.ack !== e.ack || o.data !== e.data) begin
        n_fail++;
        $display("FAIL single_grant: idx=%0d ack=%b data=%h want idx=%0d ack=%b data=%h",
                 o.idx, o.ack, o.data, e.idx, e.ack, e.data);
      end
    end
  endtask

  task automatic test_all_four();
    rec_t e, o;
    int prev = -1;
    apply_reset();
    req_data = 32'h44332211;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) push_exp(predict(req, m_ptr));
    wait_obs(1000);
    @(negedge clk);
    req = 4'b0000;
    wait_idle();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rr_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.idx !== e.idx || o.ack !== e.ack || o.data !== e.data) begin
        n_fail++;
        $display("FAIL rr_order: idx=%0d ack=%b data=%h want idx=%0d ack=%b data=%h",
                 o.idx, o.ack, o.data, e.idx, e.ack, e.data);
      end
      // 1 cycle to drop available, FRAME low cycles, then WAIT_DONE->IDLE->ISSUE.
      if (prev >= 0) begin
        n_checks++;
        if (o.cyc - prev != FRAME + 3) begin
          n_fail++;
          $display("FAIL rr_spacing: got %0d want %0d", o.cyc - prev, FRAME + 3);
        end
      end
      prev = o.cyc;
    end
  endtask

  task automatic test_two_contenders();
    rec_t e, o;
    apply_reset();
    req_data = 32'hC300B100;
    req = 4'b1010;
    for (int i = 0; i < 3; i++) push_exp(predict(req, m_ptr));
    wait_obs(1000);
    @(negedge clk);
    req = 4'b0000;
    wait_idle();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL contend_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.idx !== e.idx || o.ack !== e.ack || o.data !== e.data) begin
        n_fail++;
        $display("FAIL contend_order: idx=%0d ack=%b data=%h want idx=%0d ack=%b data=%h",
                 o.idx, o.ack, o.data, e.idx, e.ack, e.data);
      end
    end
  endtask

  task automatic test_timeout();
    rec_t e, o;
    int s_cyc = 0;
    int budget = 100;
    hold_avail = 1'b1;
    apply_reset();
    req_data[23:16] = 8'h7E;
    req = 4'b0100;
    push_exp(predict(req, m_ptr));
    do begin
      @(negedge clk);
      budget--;
    end while (!o_tx_start && budget > 0);
    s_cyc = cyc;
    @(negedge clk);
    req = 4'b0000;
    budget = 100;
    while (!o_timeout && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_checks++;
    if (o_timeout !== 1'b1 || cyc - s_cyc != TO + 1) begin
      n_fail++;
      $display("FAIL timeout_delay: pulse=%b after %0d cycles want 1 after %0d",
               o_timeout, cyc - s_cyc, TO + 1);
    end
    @(negedge clk);
    n_checks++;
    if (o_timeout !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: timeout=%b busy=%b want 0/0", o_timeout, o_busy);
    end
    hold_avail = 1'b0;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL timeout_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.idx !== e.idx || o.ack !== e.ack || o.data !== e.data) begin
        n_fail++;
        $display("FAIL timeout_grant: idx=%0d data=%h want idx=%0d data=%h", o.idx, o.data, e.idx, e.data);
      end
    end
  endtask

  task automatic test_reset_mid();
    rec_t e, o;
    apply_reset();
    req_data[31:24] = 8'h3C;
    req = 4'b1000;
    push_exp(predict(req, m_ptr));
    wait_obs(200);
    @(negedge clk);
    req = 4'b0000;
    repeat (4) @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b1 || tx_avail !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_pre: busy=%b avail=%b want 1/0", o_busy, tx_avail);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({o_busy, o_tx_start, o_timeout, o_ack, o_tx_data, o_grant_idx} !== 16'h0) begin
      n_fail++;
      $display("FAIL midrst_outputs: busy=%b start=%b to=%b ack=%b data=%h idx=%0d want all 0",
               o_busy, o_tx_start, o_timeout, o_ack, o_tx_data, o_grant_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    e = exp_q.pop_front();
    o = obs_q.pop_front();
    n_checks++;
    if (o.idx !== e.idx || o.data !== e.data) begin
      n_fail++;
      $display("FAIL midrst_first: idx=%0d data=%h want idx=%0d data=%h", o.idx, o.data, e.idx, e.data);
    end
    repeat (30) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_quiet: got %0d acks want 0", obs_q.size());
    end
    req_data[15:8] = 8'h1B;
    req = 4'b0010;
    push_exp(predict(req, m_ptr));
    wait_obs(200);
    @(negedge clk);
    req = 4'b0000;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.idx !== e.idx || o.ack !== e.ack || o.data !== e.data) begin
        n_fail++;
        $display("FAIL midrst_regrant: idx=%0d ack=%b data=%h want idx=%0d ack=%b data=%h",
                 o.idx, o.ack, o.data, e.idx, e.ack, e.data);
      end
    end
  endtask

  task automatic test_withdraw();
    rec_t e, o;
    apply_reset();
    req_data = 32'h0062615A;
    req = 4'b0001;
    push_exp(predict(req, m_ptr));
    wait_obs(200);
    @(negedge clk);
    req = 4'b0110;
    repeat (3) @(negedge clk);
    req = 4'b0100;
    push_exp(predict(req, m_ptr));
    wait_obs(500);
    @(negedge clk);
    req = 4'b0000;
    wait_idle();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL withdraw_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.idx !== e.idx || o.ack !== e.ack || o.data !== e.data) begin
        n_fail++;
        $display("FAIL withdraw_order: idx=%0d ack=%b data=%h want idx=%0d ack=%b data=%h",
                 o.idx, o.ack, o.data, e.idx, e.ack, e.data);
      end
    end
  endtask

  task automatic test_tx_unavailable();
    rec_t e, o;
    logic quiet = 1'b1;
    apply_reset();
    force_busy = 1'b1;
    req_data[7:0] = 8'hE7;
    req = 4'b0001;
    repeat (6) begin
      @(negedge clk);
      if (o_busy || o_tx_start) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL unavail_nogrant: grant seen=%b want 0", ~quiet);
    end
    force_busy = 1'b0;
    push_exp(predict(req, m_ptr));
    wait_obs(200);
    @(negedge clk);
    req = 4'b0000;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL unavail_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.idx !== e.idx || o.ack !== e.ack || o.data !== e.data) begin
        n_fail++;
        $display("FAIL unavail_grant: idx=%0d data=%h want idx=%0d data=%h", o.idx, o.data, e.idx, e.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_two_contenders();
    test_timeout();
    test_reset_mid();
    test_withdraw();
    test_tx_unavailable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation still running at time %0t", $time);
    $fatal(1, "global time limit reached");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` instance between `N_REQ` byte-wide requesters. It sits between the requesters and `uart_tx`, and sequences each transfer through the `i_start` / `o_available_tx` handshake. Each granted byte is latched, issued with a one-cycle start pulse, and tracked until the transmitter is free again. A watchdog recovers if the transmitter never acknowledges a start.

## Interface
Parameters:
- `NB_DATA`, 8, byte width; must match the `uart_tx` setting.
- `N_REQ`, 4, number of requesters (2..8).
- `NB_REQ_IDX`, `$clog2(N_REQ)`, width of the requester index.
- `TIMEOUT_CYCLES`, 1023, maximum number of clocks in `WAIT_BUSY` before abort.
- `NB_TIMEOUT`, `$clog2(TIMEOUT_CYCLES+1)`, width of the watchdog counter.

Ports (one clock; reset is asynchronous and active-high):
- `i_clock`  in  1  system clock.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_req`  in  `N_REQ`  bit k high means requester k has a byte pending.
- `i_req_data`  in  `N_REQ*NB_DATA`  requester k's byte in bits `[k*NB_DATA +: NB_DATA]`.
- `o_ack`  out  `N_REQ`  one-hot, one-cycle pulse: requester's byte has been issued to `uart_tx`.
- `o_tx_start`  out  1  to `uart_tx.i_start`; one-cycle pulse.
- `o_tx_data`  out  `NB_DATA`  to `uart_tx.i_data`; held stable from grant until return to IDLE.
- `i_tx_available`  in  1  from `uart_tx.o_available_tx`.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_grant_idx`  out  `NB_REQ_IDX`  index of the current or last granted requester.
- `o_timeout`  out  1  one-cycle pulse when the watchdog aborts a transfer.

## Operation
The arbiter is a four-state FSM: `IDLE`, `ISSUE`, `WAIT_BUSY`, `WAIT_DONE`.
- **IDLE:**
  - If any `i_req` bit is high and `i_tx_available` is 1:
    - Select the first requesting index scanning upward, with wrap, from `rr_ptr`.
    - Latch that requester's data into `o_tx_data` and set `o_grant_idx`.
    - Set `rr_ptr` to `idx+1`, wrapping to 0 after `N_REQ-1`.
    - Go to `ISSUE`.
  - Otherwise stay in `IDLE`.
- **ISSUE:** assert `o_tx_start`=1 and `o_ack[o_grant_idx]`=1 for exactly this cycle. Clear the watchdog. Go to `WAIT_BUSY`.
- **WAIT_BUSY:**
  - If `i_tx_available`=0, go to `WAIT_DONE`.
  - Else, if the watchdog equals `TIMEOUT_CYCLES`, pulse `o_timeout` and go to `IDLE`.
  - Else, increment the watchdog.
- **WAIT_DONE:** when `i_tx_available`=1, go to `IDLE`. This state has no timeout: the frame length is bounded by `uart_tx`.

Other rules:
- Requesters must hold `i_req` and their data until `o_ack`.
- A requester that drops `i_req` before its grant is simply skipped.
- A requester must deassert `i_req` on the cycle after `o_ack`, or present its next byte.
- `i_req` changes during `ISSUE`, `WAIT_BUSY` or `WAIT_DONE` have no effect until the next `IDLE` evaluation.
- `rr_ptr` does not advance on a timeout abort in round-robin mode. The aborted requester has already been acked; recovery is the requester's responsibility.

## Timing
- **Reset values:** state=`IDLE`, `rr_ptr`=0, watchdog=0, `o_tx_data`=0, `o_grant_idx`=0. `o_ack`, `o_tx_start`, `o_busy` and `o_timeout` are all 0.
- **Request-to-start latency:** a request seen in `IDLE` at cycle t gives `o_tx_start` and `o_ack` at cycle t+1.
- **Back-to-back:** the minimum spacing between two starts is one `uart_tx` frame plus 2 clocks (`WAIT_DONE`→`IDLE`→`ISSUE`).
- **Idle transmitter required:** if `i_tx_available`=0 while in `IDLE` (for example, just after reset), no grant is made.
- **Reset mid-transfer:** all state returns to reset values immediately. No `o_ack` or `o_tx_start` is produced. The `uart_tx` instance shares the same reset.
- **All requests simultaneously after reset:** grants are issued in order 0,1,2,3,0, ...

## Configuration
- `UART_ARB_FIXED_PRIO_EN` defined: fixed priority. The lowest requesting index always wins, and `rr_ptr` is neither used nor synthesized.
- `UART_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described in Operation.

## Structure
- Shared package `uart_pkg`: FSM state enum (`IDLE`, `ISSUE`, `WAIT_BUSY`, `WAIT_DONE`) and the default `NB_DATA` constant. The existing `uart_tx` and `baudrate_generator` use the same package.
- One sub-module, `rr_select`: combinational rotate-and-priority-encode.
  - Inputs: `i_req`, `rr_ptr`.
  - Outputs: a valid flag and the selected index.
  - Under `UART_ARB_FIXED_PRIO_EN`, the rotation amount is forced to 0.

## Test plan
All scenarios connect a real `uart_tx` and `baudrate_generator` with 100 MHz clock, 9600 baud, `NB_DATA`=8, `N_REQ`=4.
1. **Single requester:** reset, then requester 2 requests `8'hA5` → `o_ack`=`4'b0100` one cycle after the request, `o_tx_start` pulses once, and the serial line carries `A5` (LSB first).
2. **All four request continuously**, data `8'h11`/`22`/`33`/`44` → byte order on the line is 11, 22, 33, 44, 11; each `o_ack` is one-hot, and consecutive starts are separated by one frame plus ≥2 clocks.
3. **`UART_ARB_FIXED_PRIO_EN` defined**, requesters 1 and 3 both requesting continuously → only requester 1 is granted while it keeps requesting.
4. **Stubbed `i_tx_available` held at 1** (no drop), `TIMEOUT_CYCLES`=15 → `o_timeout` pulses 16 cycles after `o_tx_start`, then the FSM is back in `IDLE`.
5. **Reset asserted during `WAIT_DONE`** → all outputs are at reset values in the same cycle, and no further `o_ack` appears until a new request.
6. **`i_req` withdrawn before grant** while the transmitter is busy → that requester gets no `o_ack`, and the next requester in round-robin order is granted.
